// File: rtl/gates_checker_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gates_checker_pkg: FSM encodings and expected LEDR vectors for the sweep. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package gates_checker_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam int LB_NOT_A = 0;
  localparam int LB_NOT_B = 1;
  localparam int LB_AND   = 2;
  localparam int LB_OR    = 3;
  localparam int LB_NAND  = 4;
  localparam int LB_NOR   = 5;
  localparam int LB_XOR   = 6;
  localparam int LB_XNOR  = 7;

  function automatic logic [7:0] gates_vec(input logic a, input logic b);
    logic [7:0] v;
    v           = '0;
    v[LB_NOT_A] = ~a;
    v[LB_NOT_B] = ~b;
    v[LB_AND]   = a & b;
    v[LB_OR]    = a | b;
    v[LB_NAND]  = ~(a & b);
    v[LB_NOR]   = ~(a | b);
    v[LB_XOR]   = a ^ b;
    v[LB_XNOR]  = ~(a ^ b);
    return v;
  endfunction

  localparam logic [7:0] EXP_00 = gates_vec(1'b0, 1'b0);
  localparam logic [7:0] EXP_01 = gates_vec(1'b0, 1'b1);
  localparam logic [7:0] EXP_10 = gates_vec(1'b1, 1'b0);
  localparam logic [7:0] EXP_11 = gates_vec(1'b1, 1'b1);

  function automatic logic [7:0] exp_lookup(input logic [1:0] idx);
    logic [7:0] e;
    case (idx)
      2'd0:    e = EXP_00;
      2'd1:    e = EXP_01;
      2'd2:    e = EXP_10;
      default: e = EXP_11;
    endcase
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gates_settle_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gates_settle_timer: loadable down-counter that flags the settle interval. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gates_settle_timer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic zero_o
);

  localparam int             CW       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]  LOAD_VAL = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/gates_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gates_checker: sweeps A/B over all four inputs and checks LEDR results.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gates_checker
  import gates_checker_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [7:0] CHECK_MASK    = 8'hFF
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       START,
  input  logic [7:0] LEDR_IN,
  output logic       A_OUT,
  output logic       B_OUT,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] FAIL_MASK,
  output logic [7:0] ERR_BITS
);

  logic [1:0] state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] fail_q, fail_d;
  logic [7:0] err_q, err_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       timer_load, timer_zero;
  logic [7:0] diff;

  gates_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk_i (CLOCK_50),
    .rst_i (RESET),
    .load_i(timer_load),
    .en_i  (state_q == ST_DRIVE),
    .zero_o(timer_zero)
  );

  assign diff = (LEDR_IN ^ exp_lookup(idx_q)) & CHECK_MASK;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    fail_d     = fail_q;
    err_d      = err_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    timer_load = 1'b0;
    case (state_q)
      // FINISH accepts a new run exactly like IDLE; results hold otherwise.
      ST_IDLE, ST_FINISH: begin
        if (START) begin
          state_d    = ST_DRIVE;
          idx_d      = 2'd0;
          fail_d     = 4'd0;
          err_d      = 8'd0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
          timer_load = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (timer_zero) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        err_d         = err_q | diff;
        fail_d[idx_q] = |diff;
        if (idx_q == 2'd3) begin
          state_d = ST_FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_d == 4'd0);
        end else begin
          state_d    = ST_DRIVE;
          idx_d      = idx_q + 2'd1;
          timer_load = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      fail_q  <= 4'd0;
      err_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign A_OUT     = idx_q[1];
  assign B_OUT     = idx_q[0];
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign FAIL_MASK = fail_q;
  assign ERR_BITS  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_gates_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gates_checker: random sweeps against a behavioural model of the sweep. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_gates_checker;

  localparam int S     = 4;
  localparam int SWEEP = 4 * (S + 1);

  logic       clk = 1'b0;
  logic       rst, start, cmp_en;
  logic [7:0] ledr, corrupt;
  int         fault;
  int         checks = 0;
  int         errors = 0;

  logic       a0, b0, busy0, done0, pass0;
  logic [3:0] fm0;
  logic [7:0] eb0;
  logic       a1, b1, busy1, done1, pass1;
  logic [3:0] fm1;
  logic [7:0] eb1;

  always #5 clk = ~clk;

  gates_checker #(.SETTLE_CYCLES(S), .CHECK_MASK(8'hFF)) dut0 (
    .CLOCK_50(clk), .RESET(rst), .START(start), .LEDR_IN(ledr),
    .A_OUT(a0), .B_OUT(b0), .BUSY(busy0), .DONE(done0), .PASS(pass0),
    .FAIL_MASK(fm0), .ERR_BITS(eb0));

  gates_checker #(.SETTLE_CYCLES(S), .CHECK_MASK(8'h7F)) dut1 (
    .CLOCK_50(clk), .RESET(rst), .START(start), .LEDR_IN(ledr),
    .A_OUT(a1), .B_OUT(b1), .BUSY(busy1), .DONE(done1), .PASS(pass1),
    .FAIL_MASK(fm1), .ERR_BITS(eb1));

  // Reference gates block: bit0 ~A, 1 ~B, 2 AND, 3 OR, 4 NAND, 5 NOR, 6 XOR, 7 XNOR.
  function automatic logic [7:0] ref_gates(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, ~b, ~a};
  endfunction

  function automatic logic [7:0] mask_of(input int k);
    return (k == 0) ? 8'hFF : 8'h7F;
  endfunction

  always_comb begin
    ledr = ref_gates(a0, b0);
    case (fault)
      1:       ledr[6] = 1'b0;
      2:       ledr    = 8'h00;
      3:       ledr[7] = 1'b1;
      4:       ledr    = ledr ^ corrupt;
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position p = edges since the accepted START edge; a sample falls on
  // every edge where p is a multiple of S+1, the sweep ends at p = 4*(S+1).
  logic       m_active [2];
  int         m_p      [2];
  logic [3:0] m_fail   [2];
  logic [7:0] m_err    [2];
  logic       m_done   [2];
  logic       m_pass   [2];
  logic [1:0] m_ab     [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_active[k] = 1'b0; m_p[k] = 0; m_fail[k] = '0; m_err[k] = '0;
        m_done[k] = 1'b0; m_pass[k] = 1'b0; m_ab[k] = 2'd0;
      end else if (!m_active[k]) begin
        if (start) begin
          m_active[k] = 1'b1; m_p[k] = 0; m_fail[k] = '0; m_err[k] = '0;
          m_done[k] = 1'b0; m_pass[k] = 1'b0; m_ab[k] = 2'd0;
        end
      end else begin
        m_p[k] = m_p[k] + 1;
        if (m_p[k] % (S + 1) == 0) begin
          int         idx;
          logic [7:0] d;
          idx = m_p[k] / (S + 1) - 1;
          d   = (ledr ^ ref_gates(idx[1], idx[0])) & mask_of(k);
          m_err[k] = m_err[k] | d;
          if (d != 8'h00) m_fail[k][idx] = 1'b1;
        end
        if (m_p[k] == SWEEP) begin
          m_active[k] = 1'b0;
          m_done[k]   = 1'b1;
          m_pass[k]   = (m_fail[k] == 4'd0);
          m_ab[k]     = 2'd3;
        end else begin
          m_ab[k] = 2'(m_p[k] / (S + 1));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("dut0 ab",   32'({a0, b0}), 32'(m_ab[0]));
      chk("dut0 busy", 32'(busy0),    32'(m_active[0]));
      chk("dut0 done", 32'(done0),    32'(m_done[0]));
      chk("dut0 pass", 32'(pass0),    32'(m_pass[0]));
      chk("dut0 fail", 32'(fm0),      32'(m_fail[0]));
      chk("dut0 err",  32'(eb0),      32'(m_err[0]));
      chk("dut1 ab",   32'({a1, b1}), 32'(m_ab[1]));
      chk("dut1 busy", 32'(busy1),    32'(m_active[1]));
      chk("dut1 done", 32'(done1),    32'(m_done[1]));
      chk("dut1 pass", 32'(pass1),    32'(m_pass[1]));
      chk("dut1 fail", 32'(fm1),      32'(m_fail[1]));
      chk("dut1 err",  32'(eb1),      32'(m_err[1]));
    end
  end

  // Called right after a negedge: one-cycle START pulse, then exact DONE latency.
  task automatic sweep_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (SWEEP - 1) @(negedge clk);
    chk("latency done low", 32'(done0), 32'd0);
    @(negedge clk);
    chk("latency done high", 32'(done0), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; fault = 0; corrupt = 8'h00; cmp_en = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset busy", 32'(busy0), 32'd0);
    chk("reset done", 32'(done0), 32'd0);
    chk("reset ab",   32'({a0, b0}), 32'd0);
    chk("reset fail", 32'(fm0), 32'd0);
    chk("reset err",  32'(eb0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    fault = 0; sweep_pulse();
    chk("t1 pass", 32'(pass0), 32'd1);
    chk("t1 fail", 32'(fm0), 32'h0);
    chk("t1 err",  32'(eb0), 32'h00);
    chk("t1 ab",   32'({a0, b0}), 32'd3);

    fault = 1; sweep_pulse();
    chk("t2 fail", 32'(fm0), 32'h6);
    chk("t2 err",  32'(eb0), 32'h40);
    chk("t2 pass", 32'(pass0), 32'd0);

    fault = 2; sweep_pulse();
    chk("t3 fail", 32'(fm0), 32'hF);
    chk("t3 err",  32'(eb0), 32'hFF);
    chk("t3 pass", 32'(pass0), 32'd0);

    fault = 3; sweep_pulse();
    chk("t4 masked pass", 32'(pass1), 32'd1);
    chk("t4 masked err",  32'(eb1), 32'h00);
    chk("t4 full fail",   32'(fm0), 32'h6);
    chk("t4 full err",    32'(eb0), 32'h80);

    fault = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5 busy", 32'(busy0), 32'd0);
    chk("t5 ab",   32'({a0, b0}), 32'd0);
    chk("t5 fail", 32'(fm0), 32'h0);
    sweep_pulse();
    chk("t5 pass", 32'(pass0), 32'd1);

    start = 1'b1;
    repeat (SWEEP) @(negedge clk);
    chk("t6 busy held", 32'(busy0), 32'd1);
    chk("t6 done low",  32'(done0), 32'd0);
    @(negedge clk);
    chk("t6 done",      32'(done0), 32'd1);
    @(negedge clk);
    chk("t6 restart done", 32'(done0), 32'd0);
    chk("t6 restart busy", 32'(busy0), 32'd1);
    chk("t6 restart ab",   32'({a0, b0}), 32'd0);
    start = 1'b0;
    repeat (SWEEP + 2) @(negedge clk);

    for (int it = 0; it < 40; it++) begin
      fault   = int'($urandom_range(0, 4));
      corrupt = 8'($urandom) & 8'($urandom);
      start   = 1'b1;
      repeat ($urandom_range(1, 30)) @(negedge clk);
      start = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(0, 15)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      repeat ($urandom_range(SWEEP, SWEEP + 6)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
